// File: rtl/lut_tmux_sched.sv
// lut_tmux_sched
// Shares one 4-input LUT evaluation cell across NUM_OUT primary outputs.
// Each output slot stores a 16-bit truth table plus four input selectors,
// loaded through a small config port while the block is idle. A start pulse
// snapshots pi, evaluates one slot per cycle into a shadow register, and then
// publishes every po bit at once together with a one-cycle done pulse.
//
// Ports:
//   clk       rising-edge clock for all state
//   rst_n     synchronous active-low reset
//   pi        primary inputs, captured when a sweep starts
//   start     launches a sweep; only looked at while idle
//   cfg_we    config write strobe
//   cfg_addr  slot index for the config write
//   cfg_data  {sel3, sel2, sel1, sel0, tt[15:0]}; sel0 drives LUT index bit 0
//   cfg_err   one-cycle pulse after a rejected config write
//   busy      high while slots are being evaluated
//   done      one-cycle pulse in the cycle po is updated
//   po        registered evaluated outputs, held between sweeps
module lut_tmux_sched #(
   parameter int NUM_IN  = 6,
   parameter int NUM_OUT = 6,
   parameter int SEL_W   = 3,
   parameter int ADDR_W  = 3
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic [NUM_IN-1:0]        pi,
   input  logic                     start,
   input  logic                     cfg_we,
   input  logic [ADDR_W-1:0]        cfg_addr,
   input  logic [16+4*SEL_W-1:0]    cfg_data,
   output logic                     cfg_err,
   output logic                     busy,
   output logic                     done,
   output logic [NUM_OUT-1:0]       po
);

   localparam int CFG_W = 16 + 4 * SEL_W;
   localparam int SEL_N = 1 << SEL_W;
   localparam logic [ADDR_W:0]   NUM_OUT_EXT = (ADDR_W + 1)'(NUM_OUT);
   localparam logic [ADDR_W-1:0] LAST_SLOT   = ADDR_W'(NUM_OUT - 1);

   typedef enum logic [1:0] {
      IDLE,
      EVAL,
      DONE
   } state_t;

   state_t              state;
   state_t              state_next;
   logic [CFG_W-1:0]    cfg_mem [NUM_OUT];
   logic [ADDR_W-1:0]   slot;
   logic [NUM_IN-1:0]   pi_q;
   logic [NUM_OUT-1:0]  shadow;
   logic [NUM_OUT-1:0]  shadow_next;
   logic [CFG_W-1:0]    cur_word;
   logic [SEL_N-1:0]    pi_ext;
   logic [3:0]          lut_idx;
   logic                lut_bit;
   logic                last_slot;
   logic                cfg_ok;

   // The pi snapshot is zero-extended to the full selector range so that any
   // selector code at or above NUM_IN reads a constant 0; the all-ones code is
   // the conventional "unused input" value.
   assign pi_ext    = {{(SEL_N - NUM_IN){1'b0}}, pi_q};
   assign cur_word  = cfg_mem[slot];
   assign last_slot = (slot == LAST_SLOT);
   assign cfg_ok    = (state == IDLE) && ({1'b0, cfg_addr} < NUM_OUT_EXT);

   // The shared LUT cell: pick the four inputs named by the current slot's
   // selectors, form the truth-table index and look up the result bit. The
   // shadow copy with that bit merged in is what po takes on the last slot,
   // so the final result does not need an extra cycle to land in shadow first.
   always_comb begin
      lut_idx     = '0;
      shadow_next = shadow;
      for (int k = 0; k < 4; k++) begin
         lut_idx[k] = pi_ext[cur_word[16 + k*SEL_W +: SEL_W]];
      end
      lut_bit = cur_word[lut_idx];
      if (state == EVAL) begin
         shadow_next[slot] = lut_bit;
      end
   end

   // Sweep sequencing: idle until start, one slot per cycle, then a single
   // publish cycle. busy and done come straight from the registered state so
   // they are glitch-free and line up with the po update.
   always_comb begin
      state_next = state;
      busy       = 1'b0;
      done       = 1'b0;
      case (state)
         IDLE: begin
            if (start) begin
               state_next = EVAL;
            end
         end
         EVAL: begin
            busy = 1'b1;
            if (last_slot) begin
               state_next = DONE;
            end
         end
         DONE: begin
            done       = 1'b1;
            state_next = IDLE;
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   // State register and sweep datapath. Reset anywhere, including mid-sweep,
   // drops the sweep and clears po, so a partially evaluated shadow never
   // becomes visible.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state  <= IDLE;
         slot   <= '0;
         pi_q   <= '0;
         shadow <= '0;
         po     <= '0;
      end else begin
         state <= state_next;
         if (state == IDLE && start) begin
            pi_q <= pi;
            slot <= '0;
         end
         if (state == EVAL) begin
            shadow <= shadow_next;
            if (last_slot) begin
               po <= shadow_next;
            end else begin
               slot <= slot + 1'b1;
            end
         end
      end
   end

   // Config storage. Writes land only while idle and only for existing slots;
   // anything else is dropped and flagged for one cycle. A write on the same
   // edge as start is still taken, and the sweep sees it because slots are
   // read during EVAL rather than at launch.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         cfg_err <= 1'b0;
         for (int i = 0; i < NUM_OUT; i++) begin
            cfg_mem[i] <= '0;
         end
      end else begin
         cfg_err <= 1'b0;
         if (cfg_we) begin
            if (cfg_ok) begin
               cfg_mem[cfg_addr] <= cfg_data;
            end else begin
               cfg_err <= 1'b1;
            end
         end
      end
   end

endmodule

// File: doc/lut_tmux_sched.md
Name: lut_tmux_sched

Overview:
- Time-multiplexes one generic 4-input LUT evaluation cell across NUM_OUT primary outputs.
- Each output slot holds a 16-bit truth table and four input selectors, written through a config port.
- A start pulse snapshots pi, sweeps the slots one per cycle, then publishes all po bits together with a done pulse.
- Sits between the config loader and the mapped-netlist outputs. It replaces per-output Y-cell instances when area matters more than latency.

Parameters:
- NUM_IN, 6, number of primary inputs pi.
- NUM_OUT, 6, number of output slots / po bits.
- SEL_W, 3, selector field width; must satisfy 2**SEL_W > NUM_IN so that one code can select constant 0.
- ADDR_W, 3, config address width; must satisfy 2**ADDR_W >= NUM_OUT.

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst_n  in  1  synchronous active-low reset.
- pi  in  NUM_IN  primary inputs, sampled on start.
- start  in  1  begin one evaluation sweep; level-sampled, used only in IDLE.
- cfg_we  in  1  config write strobe.
- cfg_addr  in  ADDR_W  slot index to write.
- cfg_data  in  16+4*SEL_W  slot config word:
  - [15:0] truth table tt.
  - [16+SEL_W-1:16] sel0, then sel1, sel2, sel3 packed upward (sel0 is LUT index bit 0).
- cfg_err  out  1  one-cycle pulse when a write is rejected.
- busy  out  1  sweep in progress.
- done  out  1  one-cycle pulse when po has been updated.
- po  out  NUM_OUT  evaluated outputs, registered.

Behaviour:
- Reset values (rst_n=0 at a rising edge):
  - All config words = 0, so every slot evaluates to 0.
  - po=0, done=0, busy=0, cfg_err=0, state=IDLE, slot=0, pi snapshot=0.
  - Reset mid-sweep aborts the sweep. po stays 0 and no done pulse is issued.
- States: IDLE, EVAL, DONE.
- IDLE:
  - If start=1 at edge T: pi_q<=pi, slot<=0, go to EVAL.
  - busy=1 from cycle T+1.
- EVAL (cycles T+1 .. T+NUM_OUT):
  - Input lookup: in_k = pi_q[sel_k] if sel_k < NUM_IN, else 0.
  - LUT index: idx = {in3,in2,in1,in0}.
  - Result: shadow[slot] <= tt[idx].
  - If slot == NUM_OUT-1, go to DONE; otherwise slot<=slot+1.
- DONE (cycle T+NUM_OUT+1):
  - po<=shadow on entry, so all bits change together and are visible in this cycle.
  - done=1 and busy=0 for this single cycle, then return to IDLE.
  - Back-to-back sweeps: start sampled in DONE is ignored. Earliest restart is the next IDLE cycle, giving a period of NUM_OUT+2 cycles.
- start while busy or in DONE: ignored. No queuing, no error.
- Config writes:
  - Accepted only in IDLE with cfg_addr < NUM_OUT. The word is visible to a sweep started on the following edge or later.
  - cfg_we in EVAL/DONE, or with cfg_addr >= NUM_OUT: write dropped, cfg_err=1 next cycle.
  - Simultaneous cfg_we and start in IDLE: the write is accepted and start launches the sweep on the same edge. The sweep uses the newly written word, because the slot is read in EVAL.
- po holds its value between sweeps. pi changes during a sweep have no effect, since only the snapshot pi_q is evaluated.
- Constant-0 selector: sel = 2**SEL_W-1 (7 at defaults). Unused LUT inputs use this code.

Test Plan:
- Reset, then start with pi=6'b111111 and no config -> done at T+7; po=6'b000000; busy high for cycles T+1..T+6.
- Program slot0 = AND(pi0,pi1): tt=16'h0008, sel=0,1,7,7. Slot1 = OR(pi0,pi1): tt=16'h000E, sel=0,1,7,7. Slot2 = AND(pi0..pi3): tt=16'h8000, sel=0,1,2,3.
  - pi=6'b001111 -> po[2:0]=3'b111.
  - pi=6'b000001 -> po[2:0]=3'b010.
- Slot3 = pi2&pi3&(pi4|pi5) (tt=16'hE000, sel=4,5,2,3). Slot4 = (pi2&pi3)|pi4|pi5 (tt=16'hFFF8, sel=2,3,4,5).
  - pi=6'b011100 -> po[4:3]=2'b11.
  - pi=6'b010000 -> po[4:3]=2'b10.
- cfg_we during EVAL, and cfg_we with cfg_addr=6 in IDLE -> each gives cfg_err pulse; a following sweep shows the slot contents unchanged.
- Toggle pi and hold start=1 throughout a sweep -> po reflects the T snapshot; start ignored until IDLE; second done exactly 8 cycles after the first.
- Assert rst_n=0 at cycle T+3 of a sweep -> no done pulse; po=0; config cleared, so the next sweep yields po=0.
